// File: rtl/pushbutton_debounce_pio.sv
// Avalon-MM pushbutton PIO: 2-FF sync, per-bit debounce, edge-select capture with W1C and level IRQ.
// Define PIO_EVENT_COUNT_EN to add a saturating 16-bit event counter at word address 7.
module pushbutton_debounce_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]             sync1_q, sync1_d;
    logic [WIDTH-1:0]             sync2_q, sync2_d;
    logic [WIDTH-1:0]             stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]             irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]             edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0]             rise_en_q, rise_en_d;
    logic [WIDTH-1:0]             fall_en_q, fall_en_d;
    logic [31:0]                  readdata_q, readdata_d;
    logic [WIDTH-1:0]             ev;
    logic [WIDTH-1:0]             w1c;
    logic                         wr;
    logic [WIDTH-1:0]             wdata;
    logic                         unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Synchroniser and per-bit debounce; ev marks an accepted transition of an enabled polarity.
    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        ev       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                ev[i]       = sync2_q[i] ? rise_en_q[i] : fall_en_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        w1c        = '0;
        if (wr) begin
            case (address)
                3'd2:    irq_mask_d = wdata;
                3'd3:    w1c        = wdata;
                3'd4:    rise_en_d  = wdata;
                3'd5:    fall_en_d  = wdata;
                default: ;
            endcase
        end
        // A new event wins over a same-cycle clear.
        edge_capture_d = (edge_capture_q & ~w1c) | ev;
    end

`ifdef PIO_EVENT_COUNT_EN
    logic [15:0] ev_count_q, ev_count_d;

    always_comb begin
        ev_count_d = ev_count_q;
        if (wr && address == 3'd7) begin
            ev_count_d = {15'd0, |ev};
        end else if (|ev && ev_count_q != 16'hFFFF) begin
            ev_count_d = ev_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_count_q <= '0;
        end else begin
            ev_count_q <= ev_count_d;
        end
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = stable_q;
            3'd1:    readdata_d[WIDTH-1:0] = sync2_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
            3'd6:    readdata_d[0]         = |edge_capture_q;
`ifdef PIO_EVENT_COUNT_EN
            3'd7:    readdata_d[15:0]      = ev_count_q;
`endif
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            stable_q       <= '1;
            cnt_q          <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            rise_en_q      <= '0;
            fall_en_q      <= '1;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
